jtframe_inrec: RTL and testbench
================================

# jtframe_inrec

Per-frame input recorder for the game-side input bus. It packs coin, start, 1P joystick and test into one 16-bit word per video frame and stores it in internal RAM, in exactly the word format the simulation input reader consumes (one word per frame, starting at frame 0). A dump port lets the host or a testbench read the capture back, so a hardware play session can be replayed in simulation.

## Interface
Parameters:
- AW, 14: RAM address width. Depth is 2^AW words (16384 matches the reader).
- ACTIVE_LOW, 1: polarity of the game_coin/game_start/game_joy1 inputs. 1 means they are active-low and are inverted before packing.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- vs  in  1  vertical sync; a frame boundary is a falling edge of vs
- rec_en  in  1  level. A rising edge arms a new recording; low stops recording.
- game_pause  in  1  game paused (used only with the configuration macro)
- game_coin  in  4  coin inputs, polarity per ACTIVE_LOW
- game_start  in  4  start inputs, polarity per ACTIVE_LOW
- game_joy1  in  10  1P joystick {buttons[9:4], R/L/D/U[3:0]}, polarity per ACTIVE_LOW
- game_test  in  1  test key, always active-high
- dump_addr  in  AW  read address
- dump_dout  out  16  read data
- rec_len  out  AW+1  number of words recorded
- rec_busy  out  1  recording in progress
- rec_full  out  1  RAM filled, sticky until re-armed

## Operation
- Normalisation: coin, start and joy are XORed with ACTIVE_LOW, giving 1 = pressed.
- Word packing:
  - [1:0] coin[1:0]
  - [3:2] start[1:0]
  - [10:4] joy1[6:0]
  - [11] test
  - [15:12] 0
- vs edge detect: vsl <= vs each clock. frame_edge = !vs && vsl.
- Arming: rec_en rising (rec_en && !rec_enl) does the following:
  - rec_len <= 0
  - rec_full <= 0
  - rec_busy <= 1
  - any pending write is cancelled
- Stopping: rec_en low forces rec_busy <= 0. rec_len and rec_full hold their values.
- Capture: on frame_edge with rec_busy && !rec_full:
  - latch the packed word into wr_data
  - set wr_pend
- Write cycle (wr_pend set):
  - mem[rec_len[AW-1:0]] <= wr_data
  - rec_len <= rec_len+1
  - wr_pend <= 0
  - if the new rec_len equals 2^AW: rec_full <= 1 and rec_busy <= 0
- Full: further frame edges are ignored and nothing wraps. rec_len saturates at 2^AW.
- Dump: dump_dout <= mem[dump_addr] on every clock. The read is always enabled and independent of recording.
- Read/write collision at the same address in the same cycle: dump_dout returns the old contents (read-first).
- RAM is not cleared by rst or by arming. Words at or beyond rec_len are undefined.

## Timing
- Reset values:
  - rec_len 0, rec_busy 0, rec_full 0
  - dump_dout 0
  - wr_pend 0
  - vsl 0, rec_enl 0
- Capture latency: inputs are sampled in the cycle frame_edge is high (N). The RAM write and the rec_len increment happen at N+1. The word is readable through dump with dump_addr set from N+2, and appears on dump_dout at N+3.
- Dump read latency: 1 clock from dump_addr to dump_dout.
- Arm and frame_edge in the same cycle: arming wins and that frame is not recorded. The first recorded word is the next frame edge.
- rec_en falling while wr_pend is set: the pending write still completes, so a frame already captured is never lost.
- rst mid-recording: all state returns to reset values immediately (asynchronous). RAM contents are undefined.

## Configuration
- JTFRAME_INREC_PAUSE_EN defined: a frame_edge with game_pause=1 is skipped. No capture happens and rec_len is unchanged, so the replay timeline contains only running frames.
- JTFRAME_INREC_PAUSE_EN undefined: game_pause is ignored and every frame edge is recorded.

## Test plan
- Packing, ACTIVE_LOW=1:
  - Stimulus: arm; game_coin=4'b1110, game_start=4'b1101, game_joy1=10'h3FE, game_test=1; one vs falling edge.
  - Response: rec_len=1; dump_addr=0 gives dump_dout=16'h0819 one clock later.
- Sequence:
  - Stimulus: arm, then 5 frames with joy1 bit 0 pressed only in frame 3.
  - Response: rec_len=5; word 3 = 16'h0010; words 0-2 and 4 = 16'h0000.
- Full (AW=4):
  - Stimulus: arm, then 20 frame edges.
  - Response: rec_len=16, rec_full=1 and rec_busy=0 after the 16th write; word 15 is intact and word 0 is not overwritten.
- Re-arm:
  - Stimulus: after the full test, toggle rec_en low then high, coincident with a frame edge.
  - Response: rec_len=0, rec_full=0, rec_busy=1, and that frame is not recorded; the next edge gives rec_len=1.
- Pause, macro defined:
  - Stimulus: 4 frames with game_pause high on frames 1 and 2.
  - Response: rec_len=2.
  - Without the macro, the same stimulus gives rec_len=4.
- Reset mid-recording:
  - Stimulus: assert rst asynchronously between clock edges after 3 frames.
  - Response: rec_len, rec_busy, rec_full and dump_dout all 0 immediately; after release, no recording until rec_en rises again.

Source files
------------

// File: rtl/jtframe_inrec.sv
// rtl/jtframe_inrec.sv - per-frame game input recorder into internal RAM with a read-back dump port
// Optional macro: JTFRAME_INREC_PAUSE_EN (skip frames while game_pause is high)
module jtframe_inrec #(
  parameter int AW         = 14,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          rec_en,
  input  logic          game_pause,
  input  logic [3:0]    game_coin,
  input  logic [3:0]    game_start,
  input  logic [9:0]    game_joy1,
  input  logic          game_test,
  input  logic [AW-1:0] dump_addr,
  output logic [15:0]   dump_dout,
  output logic [AW:0]   rec_len,
  output logic          rec_busy,
  output logic          rec_full
);

  localparam logic        POL      = (ACTIVE_LOW != 0);
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  logic [15:0] mem [0:(1<<AW)-1];
  logic        vsl;
  logic        rec_enl;
  logic        wr_pend;
  logic [15:0] wr_data;
  logic [3:0]  coin_n;
  logic [3:0]  start_n;
  logic [9:0]  joy_n;
  logic [15:0] packed_word;
  logic [AW:0] next_len;
  logic        frame_edge;
  logic        arm;
  logic        skip;
  logic        capture;
  logic        do_write;

  assign coin_n      = game_coin  ^ {4{POL}};
  assign start_n     = game_start ^ {4{POL}};
  assign joy_n       = game_joy1  ^ {10{POL}};
  assign packed_word = {4'd0, game_test, joy_n[6:0], start_n[1:0], coin_n[1:0]};

  assign frame_edge = !vs && vsl;
  assign arm        = rec_en && !rec_enl;
  assign next_len   = rec_len + ONE;

`ifdef JTFRAME_INREC_PAUSE_EN
  assign skip = game_pause;
`else
  assign skip = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{game_pause, coin_n[3:2], start_n[3:2], joy_n[9:7]};

  // Arming cancels a pending write, so both the RAM and the counter see the same gate
  assign do_write = wr_pend && !arm;
  assign capture  = frame_edge && rec_busy && !rec_full && !skip && !arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsl       <= 1'b0;
      rec_enl   <= 1'b0;
      rec_len   <= '0;
      rec_busy  <= 1'b0;
      rec_full  <= 1'b0;
      wr_pend   <= 1'b0;
      wr_data   <= '0;
      dump_dout <= '0;
    end else begin
      vsl       <= vs;
      rec_enl   <= rec_en;
      dump_dout <= mem[dump_addr];
      if (arm) begin
        rec_len  <= '0;
        rec_full <= 1'b0;
        rec_busy <= 1'b1;
        wr_pend  <= 1'b0;
      end else begin
        if (!rec_en) rec_busy <= 1'b0;
        if (do_write) begin
          rec_len <= next_len;
          wr_pend <= 1'b0;
          if (next_len == FULL_LEN) begin
            rec_full <= 1'b1;
            rec_busy <= 1'b0;
          end
        end
        if (capture) begin
          wr_data <= packed_word;
          wr_pend <= 1'b1;
        end
      end
    end
  end

  // RAM has no reset; read-first behaviour falls out of the non-blocking update
  always_ff @(posedge clk) begin
    if (do_write) mem[rec_len[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_jtframe_inrec.sv
// tb/tb_jtframe_inrec.sv - directed self-checking bench for jtframe_inrec (AW=4)
module tb_jtframe_inrec;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs = 1'b0;
  logic          rec_en = 1'b0;
  logic          game_pause = 1'b0;
  logic [3:0]    game_coin = 4'hF;
  logic [3:0]    game_start = 4'hF;
  logic [9:0]    game_joy1 = 10'h3FF;
  logic          game_test = 1'b0;
  logic [AW-1:0] dump_addr = '0;
  logic [15:0]   dump_dout;
  logic [AW:0]   rec_len;
  logic          rec_busy;
  logic          rec_full;

  int n_checks = 0;
  int n_fails  = 0;

  jtframe_inrec #(.AW(AW), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .vs(vs), .rec_en(rec_en), .game_pause(game_pause),
    .game_coin(game_coin), .game_start(game_start), .game_joy1(game_joy1),
    .game_test(game_test), .dump_addr(dump_addr), .dump_dout(dump_dout),
    .rec_len(rec_len), .rec_busy(rec_busy), .rec_full(rec_full)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
    tick(3);
  endtask

  task automatic idle_inputs();
    game_coin = 4'hF; game_start = 4'hF; game_joy1 = 10'h3FF; game_test = 1'b0; game_pause = 1'b0;
  endtask

  task automatic rearm();
    rec_en = 1'b0;
    tick(1);
    rec_en = 1'b1;
    tick(1);
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [15:0] d);
    dump_addr = a;
    tick(1);
    d = dump_dout;
  endtask

  logic [15:0] w;
  int exp_pause;

  initial begin
    tick(2);
    chk("reset rec_len", 16'(rec_len), 16'd0);
    chk("reset rec_busy", 16'(rec_busy), 16'd0);
    chk("reset rec_full", 16'(rec_full), 16'd0);
    chk("reset dump_dout", dump_dout, 16'h0000);
    rst = 1'b0;
    tick(2);

    // packing
    game_coin = 4'b1110; game_start = 4'b1101; game_joy1 = 10'h3FE; game_test = 1'b1;
    rec_en = 1'b1;
    tick(1);
    chk("arm busy", 16'(rec_busy), 16'd1);
    frame();
    chk("pack rec_len", 16'(rec_len), 16'd1);
    read_word(0, w);
    chk("pack word", w, 16'h0819);

    // five-frame sequence
    idle_inputs();
    rearm();
    for (int i = 0; i < 5; i++) begin
      game_joy1 = (i == 3) ? 10'h3FE : 10'h3FF;
      frame();
    end
    idle_inputs();
    chk("seq rec_len", 16'(rec_len), 16'd5);
    for (int i = 0; i < 5; i++) begin
      read_word(AW'(i), w);
      chk($sformatf("seq word%0d", i), w, (i == 3) ? 16'h0010 : 16'h0000);
    end

    // fill to capacity, then overflow attempts carry the test bit
    rearm();
    for (int i = 0; i < 16; i++) begin
      game_coin  = {2'b11, ~i[1:0]};
      game_start = {2'b11, ~i[3:2]};
      frame();
    end
    chk("full rec_len", 16'(rec_len), 16'd16);
    chk("full rec_full", 16'(rec_full), 16'd1);
    chk("full rec_busy", 16'(rec_busy), 16'd0);
    game_test = 1'b1;
    for (int i = 0; i < 4; i++) frame();
    idle_inputs();
    chk("sat rec_len", 16'(rec_len), 16'd16);
    read_word(15, w);
    chk("full word15", w, 16'h000F);
    read_word(0, w);
    chk("full word0", w, 16'h0000);
    read_word(9, w);
    chk("full word9", w, 16'h0009);

    // re-arm on the same cycle as a frame edge
    rec_en = 1'b0;
    tick(1);
    vs = 1'b1;
    tick(2);
    game_test = 1'b1;
    vs = 1'b0;
    rec_en = 1'b1;
    tick(3);
    chk("rearm rec_len", 16'(rec_len), 16'd0);
    chk("rearm rec_full", 16'(rec_full), 16'd0);
    chk("rearm rec_busy", 16'(rec_busy), 16'd1);
    frame();
    chk("rearm next edge", 16'(rec_len), 16'd1);
    read_word(0, w);
    chk("rearm word0", w, 16'h0800);
    idle_inputs();

    // pause handling
    rearm();
    for (int i = 0; i < 4; i++) begin
      game_pause = (i == 1 || i == 2);
      frame();
    end
    game_pause = 1'b0;
`ifdef JTFRAME_INREC_PAUSE_EN
    exp_pause = 2;
`else
    exp_pause = 4;
`endif
    chk("pause rec_len", 16'(rec_len), 16'(exp_pause));

    // asynchronous reset in the middle of a recording
    rearm();
    game_test = 1'b1;
    for (int i = 0; i < 3; i++) frame();
    dump_addr = 0;
    tick(1);
    chk("pre-rst rec_len", 16'(rec_len), 16'd3);
    chk("pre-rst dump", dump_dout, 16'h0800);
    #3;
    rst = 1'b1;
    rec_en = 1'b0;
    #1;
    chk("rst rec_len", 16'(rec_len), 16'd0);
    chk("rst rec_busy", 16'(rec_busy), 16'd0);
    chk("rst rec_full", 16'(rec_full), 16'd0);
    chk("rst dump_dout", dump_dout, 16'h0000);
    #3;
    rst = 1'b0;
    tick(2);
    frame();
    chk("post-rst idle len", 16'(rec_len), 16'd0);
    chk("post-rst idle busy", 16'(rec_busy), 16'd0);
    rec_en = 1'b1;
    tick(1);
    frame();
    chk("post-rst rec len", 16'(rec_len), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
